// File: rtl/mpsse_i2c_master.sv
// Command-driven open-drain I2C master (MPSSE-style): START / WRITE / READ / STOP byte commands.
// Each data/ACK slot is four QDIV-cycle phases, and the master honours clock stretching in P2.
module mpsse_i2c_master #(
  parameter int unsigned QDIV = 4
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdat,
  input  logic       cmd_nack,
  output logic       done,
  output logic [7:0] rsp_rdat,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       CSB,
  inout  wire        SCK,
  inout  wire        SDO,
  input  logic       SDI
);

  typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop} state_e;

  localparam logic [1:0] OpStart = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [8:0] QCyc    = 9'(QDIV);
  localparam logic [8:0] HCyc    = 9'(2 * QDIV);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       rd_q, rd_d, nack_q, nack_d, own_q, own_d, hold_q, hold_d;
  logic       done_q, done_d, rnack_q, rnack_d, err_q, err_d;
  logic [7:0] rdat_q, rdat_d;
  logic       sck_low, sdo_low, scl_in, sda_in, slot, last;
  logic       unused_sdi;

  assign SCK        = sck_low ? 1'b0 : 1'bz;
  assign SDO        = sdo_low ? 1'b0 : 1'bz;
  assign scl_in     = SCK;
  assign sda_in     = SDO;
  assign unused_sdi = SDI;

  assign cmd_ready = (state_q == StIdle);
  assign done      = done_q;
  assign rsp_rdat  = rdat_q;
  assign rsp_nack  = rnack_q;
  assign rsp_err   = err_q;
  assign CSB       = ~own_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rd_d    = rd_q;
    nack_d  = nack_q;
    own_d   = own_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    rdat_d  = rdat_q;
    rnack_d = rnack_q;
    err_d   = err_q;
    sck_low = 1'b0;
    sdo_low = 1'b0;
    slot    = (state_q == StBit) || (state_q == StAck);
    last    = (cnt_q == ((slot ? QCyc : HCyc) - 9'd1));
    case (state_q)
      StIdle: begin
        // Between commands an owned bus keeps SCL low and SDA where the last command left it.
        sck_low = own_q;
        sdo_low = hold_q;
        if (cmd_valid) begin
          cnt_d   = 9'd0;
          phase_d = 2'd0;
          if (cmd_op == OpStart) begin
            state_d = StStart;
            phase_d = own_q ? 2'd0 : 2'd1;
          end else if (!own_q) begin
            done_d = 1'b1;
            err_d  = (cmd_op != 2'b11);
          end else if (cmd_op == OpWrite || cmd_op == OpRead) begin
            state_d = StBit;
            bit_d   = 3'd0;
            rd_d    = (cmd_op == OpRead);
            nack_d  = cmd_nack;
            shreg_d = (cmd_op == OpRead) ? 8'h00 : cmd_wdat;
          end else begin
            state_d = StStop;
          end
        end
      end
      StStart: begin
        sck_low = (phase_q == 2'd0);
        sdo_low = (phase_q == 2'd2);
        cnt_d   = cnt_q + 9'd1;
        if (last) begin
          cnt_d   = 9'd0;
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd2) begin
            state_d = StIdle;
            own_d   = 1'b1;
            hold_d  = 1'b1;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end
        end
      end
      StStop: begin
        sck_low = (phase_q == 2'd0);
        sdo_low = (phase_q != 2'd2);
        cnt_d   = cnt_q + 9'd1;
        if (last) begin
          cnt_d   = 9'd0;
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd2) begin
            state_d = StIdle;
            own_d   = 1'b0;
            hold_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end
        end
      end
      StBit, StAck: begin
        sck_low = (phase_q == 2'd0) || (phase_q == 2'd3);
        sdo_low = (state_q == StBit) ? (!rd_q && !shreg_q[7]) : (rd_q && !nack_q);
        // P2 waits for SCL to actually read high, so a stretching slave freezes the counter.
        if (phase_q != 2'd2 || scl_in) begin
          cnt_d = cnt_q + 9'd1;
          if (last) begin
            cnt_d   = 9'd0;
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd2) begin
              if (state_q == StBit && rd_q) shreg_d = {shreg_q[6:0], sda_in};
              if (state_q == StAck && !rd_q) rnack_d = sda_in;
            end
            if (phase_q == 2'd3) begin
              if (state_q == StBit) begin
                if (!rd_q) shreg_d = {shreg_q[6:0], 1'b0};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = StAck;
              end else begin
                state_d = StIdle;
                hold_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = 1'b0;
                if (rd_q) rdat_d = shreg_q;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstz) begin
      state_q <= StIdle;
      phase_q <= 2'd0;
      cnt_q   <= 9'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      rd_q    <= 1'b0;
      nack_q  <= 1'b0;
      own_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      rdat_q  <= 8'h00;
      rnack_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rd_q    <= rd_d;
      nack_q  <= nack_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      rdat_q  <= rdat_d;
      rnack_q <= rnack_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mpsse_i2c_master.sv
// Directed bench for mpsse_i2c_master (QDIV=4): pulled-up open-drain bus with a timed slave model.
module tb_mpsse_i2c_master;

  logic       clk = 1'b0;
  logic       rstz = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_wdat = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       sdi = 1'b0;
  logic       cmd_ready, done, rsp_nack, rsp_err, csb;
  logic [7:0] rsp_rdat;
  logic       slv_scl = 1'b0;
  logic       slv_sda = 1'b0;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);
  assign scl = slv_scl ? 1'b0 : 1'bz;
  assign sda = slv_sda ? 1'b0 : 1'bz;

  mpsse_i2c_master #(.QDIV(4)) dut (
    .clk(clk), .rstz(rstz), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdat(cmd_wdat), .cmd_nack(cmd_nack), .done(done), .rsp_rdat(rsp_rdat),
    .rsp_nack(rsp_nack), .rsp_err(rsp_err), .CSB(csb), .SCK(scl), .SDO(sda), .SDI(sdi)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic       mon_on = 1'b0;
  logic [8:0] mon_bits = '0;
  int         mon_cnt = 0;
  int         scl_falls = 0;
  int         sda_falls = 0;
  logic       stop_mon = 1'b0;
  int         stop_seen = 0;
  logic       stop_scl = 1'b0;
  int         cyc;

  always @(posedge scl) if (mon_on) begin mon_bits = {mon_bits[7:0], sda}; mon_cnt++; end
  always @(negedge scl) scl_falls++;
  always @(negedge sda) sda_falls++;
  always @(posedge sda) if (stop_mon) begin stop_seen++; stop_scl = scl; end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] wdat, input logic nack);
    cmd_op = op; cmd_wdat = wdat; cmd_nack = nack; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wdat = ~wdat; cmd_nack = ~nack;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic slave_ack();
    repeat (8) @(negedge scl);
    #1 slv_sda = 1'b1;
    @(negedge scl);
    #1 slv_sda = 1'b0;
  endtask

  task automatic slave_tx(input logic [7:0] b);
    slv_sda = ~b[7];
    for (int i = 6; i >= 0; i--) begin
      @(negedge scl);
      #1 slv_sda = ~b[i];
    end
    @(negedge scl);
    #1 slv_sda = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0, s0, dcount;
    repeat (3) @(posedge clk);
    #1 rstz = 1'b1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_csb", {31'd0, csb}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rdat", {24'd0, rsp_rdat}, 32'd0);
    check("rst_nack_err", {30'd0, rsp_nack, rsp_err}, 32'd0);
    check("rst_lines", {30'd0, scl, sda}, 32'd3);

    // READ without ownership: immediate error, no pin activity
    f0 = scl_falls; s0 = sda_falls;
    issue(2'b10, 8'h00, 1'b0);
    wait_done(cyc);
    check("noown_rd_lat", cyc, 0);
    check("noown_rd_err", {31'd0, rsp_err}, 32'd1);
    check("noown_rd_pins", scl_falls + sda_falls, f0 + s0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);

    issue(2'b00, 8'h00, 1'b0);
    wait_done(cyc);
    check("start_lat", cyc, 16);
    check("start_csb", {31'd0, csb}, 32'd0);
    check("start_err", {31'd0, rsp_err}, 32'd0);

    // WRITE 0xA6 with slave ACK
    mon_bits = '0; mon_cnt = 0; mon_on = 1'b1;
    fork slave_ack(); join_none
    issue(2'b01, 8'hA6, 1'b0);
    wait_done(cyc);
    mon_on = 1'b0;
    check("wr_a6_lat", cyc, 144);
    check("wr_a6_bits", {23'd0, mon_bits}, 32'h14C);
    check("wr_a6_rises", mon_cnt, 9);
    check("wr_a6_nack", {31'd0, rsp_nack}, 32'd0);

    // WRITE 0x55 with nobody acknowledging (back-to-back on the done cycle)
    mon_bits = '0; mon_on = 1'b1;
    issue(2'b01, 8'h55, 1'b0);
    wait_done(cyc);
    mon_on = 1'b0;
    check("wr_55_bits", {23'd0, mon_bits}, 32'h0AB);
    check("wr_55_nack", {31'd0, rsp_nack}, 32'd1);
    check("wr_55_csb", {31'd0, csb}, 32'd0);

    issue(2'b00, 8'h00, 1'b0);
    wait_done(cyc);
    check("rstart_lat", cyc, 24);

    // READ 0x3C, master NACKs
    mon_bits = '0; mon_on = 1'b1;
    fork slave_tx(8'h3C); join_none
    issue(2'b10, 8'h00, 1'b1);
    wait_done(cyc);
    mon_on = 1'b0;
    check("rd_lat", cyc, 144);
    check("rd_data", {24'd0, rsp_rdat}, 32'h3C);
    check("rd_bits_nack", {23'd0, mon_bits}, 32'h079);

    stop_seen = 0; stop_mon = 1'b1;
    issue(2'b11, 8'h00, 1'b0);
    wait_done(cyc);
    stop_mon = 1'b0;
    check("stop_lat", cyc, 24);
    check("stop_sda_rise", stop_seen, 1);
    check("stop_scl_high", {31'd0, stop_scl}, 32'd1);
    check("stop_csb", {31'd0, csb}, 32'd1);
    check("stop_rdat_held", {24'd0, rsp_rdat}, 32'h3C);

    issue(2'b11, 8'h00, 1'b0);
    wait_done(cyc);
    check("noown_stop_lat", cyc, 0);
    check("noown_stop_err", {31'd0, rsp_err}, 32'd0);

    // Slave stretches SCL into bit 3's high phase by 50 cycles
    issue(2'b00, 8'h00, 1'b0);
    wait_done(cyc);
    mon_bits = '0; mon_cnt = 0; mon_on = 1'b1;
    fork slave_ack(); join_none
    issue(2'b01, 8'h96, 1'b0);
    fork
      begin
        repeat (48) @(posedge clk);
        #1 slv_scl = 1'b1;
        repeat (58) @(posedge clk);
        #1 slv_scl = 1'b0;
      end
    join_none
    wait_done(cyc);
    mon_on = 1'b0;
    check("stretch_lat", cyc, 194);
    check("stretch_bits", {23'd0, mon_bits}, 32'h12C);
    check("stretch_nack", {31'd0, rsp_nack}, 32'd0);
    issue(2'b11, 8'h00, 1'b0);
    wait_done(cyc);

    // Reset in the middle of a WRITE, while SCL is held low in bit 3
    issue(2'b00, 8'h00, 1'b0);
    wait_done(cyc);
    issue(2'b01, 8'h5A, 1'b0);
    repeat (61) @(posedge clk);
    #1;
    check("midwr_scl_low", {31'd0, scl}, 32'd0);
    rstz = 1'b0;
    @(posedge clk); #1;
    rstz = 1'b1;
    check("midwr_lines", {30'd0, scl, sda}, 32'd3);
    check("midwr_csb", {31'd0, csb}, 32'd1);
    check("midwr_ready", {31'd0, cmd_ready}, 32'd1);
    dcount = 0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) dcount++;
      @(posedge clk); #1;
    end
    check("midwr_no_done", dcount, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
